fnd_scan_rx: RTL and testbench



---
 rtl/fnd_scan_if.sv | 25 ++
 rtl/fnd_scan_rx.sv | 175 +++++++++++++++++
 tb/tb_fnd_scan_rx.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_if.sv
// Multiplexed 7-segment display bus plus the
// frame results decoded from it by fnd_scan_rx.
interface fnd_scan_if;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [5:0]  i_seg_enb;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic [6:0]  o_sec;
  logic [6:0]  o_min;
  logic        o_frame_valid;
  logic        o_err;

  modport master (
    output i_seg, i_seg_dp, i_seg_enb,
    input  o_digits, o_dp, o_sec, o_min,
    input  o_frame_valid, o_err
  );

  modport slave (
    input  i_seg, i_seg_dp, i_seg_enb,
    output o_digits, o_dp, o_sec, o_min,
    output o_frame_valid, o_err
  );
endinterface

// File: rtl/fnd_scan_rx.sv
// Receive-side decoder for a six-digit scanned
// 7-segment bus: filters, decodes, reassembles frames.
module fnd_scan_rx #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 65536
) (
  input logic       clk,
  input logic       rst_n,
  fnd_scan_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = (TIMEOUT_CYC > 2) ?
                      $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYC);
  localparam logic [SW-1:0] S_CAP = SW'(STABLE_CYC - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef struct packed {
    logic [5:0] enb;
    logic [6:0] seg;
    logic       dp;
  } bus_t;

  typedef enum logic {HUNT, COLLECT} state_t;

  bus_t          raw;
  bus_t          q;
  logic [SW-1:0] scnt;
  logic          cap;
  logic [2:0]    idx;
  logic          one;
  logic          multi;
  logic [3:0]    dig;
  logic          bad;
  state_t        st;
  logic [2:0]    exp_idx;
  logic [TW-1:0] tmo;
  logic [3:0]    sh_d [5];
  logic [4:0]    sh_dp;

  assign raw = {bus.i_seg_enb, bus.i_seg, bus.i_seg_dp};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= {6'h3f, 7'h00, 1'b0};
      scnt <= '0;
    end else begin
      q <= raw;
      if (raw != q)
        scnt <= '0;
      else if (scnt != S_MAX)
        scnt <= scnt + SW'(1);
    end
  end

  // Fires once per dwell: the counter passes S_CAP once
  assign cap = (scnt == S_CAP);

  always_comb begin
    idx = 3'd0;
    one = 1'b1;
    case (q.enb)
      6'b111110: idx = 3'd0;
      6'b111101: idx = 3'd1;
      6'b111011: idx = 3'd2;
      6'b110111: idx = 3'd3;
      6'b101111: idx = 3'd4;
      6'b011111: idx = 3'd5;
      default:   one = 1'b0;
    endcase
  end

  assign multi = !one && (q.enb != 6'h3f);

  always_comb begin
    dig = 4'hF;
    case (q.seg)
      7'b1111110: dig = 4'h0;
      7'b0110000: dig = 4'h1;
      7'b1101101: dig = 4'h2;
      7'b1111001: dig = 4'h3;
      7'b0110011: dig = 4'h4;
      7'b1011011: dig = 4'h5;
      7'b1011111: dig = 4'h6;
      7'b1110000: dig = 4'h7;
      7'b1111111: dig = 4'h8;
      7'b1110011: dig = 4'h9;
      7'b0000000: dig = 4'hE;
      default:    dig = 4'hF;
    endcase
  end

  assign bad = (dig == 4'hF);

  function automatic logic [6:0] pair(
    input logic [3:0] t,
    input logic [3:0] o
  );
    if (t > 4'd9 || o > 4'd9)
      return 7'd127;
    return 7'(t) * 7'd10 + 7'(o);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st                <= HUNT;
      exp_idx           <= '0;
      tmo               <= '0;
      sh_dp             <= '0;
      for (int k = 0; k < 5; k++)
        sh_d[k] <= 4'hE;
      bus.o_digits      <= 24'hEEEEEE;
      bus.o_dp          <= '0;
      bus.o_sec         <= '0;
      bus.o_min         <= '0;
      bus.o_frame_valid <= 1'b0;
      bus.o_err         <= 1'b0;
    end else begin
      bus.o_frame_valid <= 1'b0;
      bus.o_err         <= 1'b0;
      if (cap && multi) begin
        bus.o_err <= 1'b1;
        st        <= HUNT;
      end else if (cap && one) begin
        tmo <= '0;
        unique case (st)
          HUNT: begin
            if (idx == 3'd0) begin
              sh_d[0]   <= dig;
              sh_dp[0]  <= q.dp;
              exp_idx   <= 3'd1;
              st        <= COLLECT;
              bus.o_err <= bad;
            end
          end
          COLLECT: begin
            bus.o_err <= bad;
            if (idx == exp_idx) begin
              if (idx == 3'd5) begin
                bus.o_digits      <= {dig, sh_d[4], sh_d[3],
                                      sh_d[2], sh_d[1], sh_d[0]};
                bus.o_dp          <= {q.dp, sh_dp};
                bus.o_sec         <= pair(sh_d[1], sh_d[0]);
                bus.o_min         <= pair(sh_d[3], sh_d[2]);
                bus.o_frame_valid <= 1'b1;
                exp_idx           <= 3'd0;
                st                <= HUNT;
              end else begin
                sh_d[idx]  <= dig;
                sh_dp[idx] <= q.dp;
                exp_idx    <= exp_idx + 3'd1;
              end
            end else begin
              bus.o_err <= 1'b1;
              if (idx == 3'd0) begin
                sh_d[0]  <= dig;
                sh_dp[0] <= q.dp;
                exp_idx  <= 3'd1;
              end else begin
                st <= HUNT;
              end
            end
          end
        endcase
      end else if (st == COLLECT) begin
        if (tmo == T_LAST) begin
          bus.o_err <= 1'b1;
          st        <= HUNT;
        end else begin
          tmo <= tmo + TW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fnd_scan_rx.sv
// Randomised and directed bench for fnd_scan_rx with a
// run-length / frame-level reference model.
module tb_fnd_scan_rx;
  localparam int STABLE = 16;
  localparam int TMO    = 3000;
  localparam logic [6:0] SEGS [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011};
  localparam logic [13:0] IDLE = {6'h3f, 7'h00, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  fnd_scan_if bus();

  fnd_scan_rx #(
    .STABLE_CYC (STABLE),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int nfv = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mdec(input logic [6:0] s);
    if (s == 7'h00) return 4'hE;
    for (int i = 0; i < 10; i++)
      if (SEGS[i] == s) return 4'(i);
    return 4'hF;
  endfunction

  function automatic int mpair(input logic [3:0] t,
                               input logic [3:0] o);
    return (t <= 9 && o <= 9) ? int'(t) * 10 + int'(o) : 127;
  endfunction

  // Reference model state
  logic [13:0] cur;
  int          run;
  bit          coll;
  int          nexti;
  int          idle;
  logic [3:0]  pd [6];
  logic [5:0]  pdp;
  logic [23:0] m_digits;
  logic [5:0]  m_dp;
  int          m_sec;
  int          m_min;
  bit          m_fv;
  bit          m_err;

  always @(posedge clk) begin : model
    logic [13:0] v;
    logic [13:0] cv;
    bit          cap;
    int          zeros;
    int          idx;
    logic [3:0]  dg;
    bit          bad;
    v = {bus.i_seg_enb, bus.i_seg, bus.i_seg_dp};
    if (!rst_n) begin
      cur = IDLE; run = 0; coll = 0; nexti = 0; idle = 0;
      m_digits = 24'hEEEEEE; m_dp = '0;
      m_sec = 0; m_min = 0; m_fv = 0; m_err = 0;
    end else begin
      m_fv = 0; m_err = 0;
      // a value captures once it has been sampled STABLE edges in a row
      cap = (run == STABLE);
      cv = cur;
      if (v == cur) run++;
      else begin cur = v; run = 1; end
      if (cap && cv[13:8] != 6'h3f) begin
        zeros = 6 - $countones(cv[13:8]);
        if (zeros > 1) begin
          m_err = 1; coll = 0;
        end else begin
          idx = 0;
          for (int k = 0; k < 6; k++)
            if (!cv[8+k]) idx = k;
          dg = mdec(cv[7:1]);
          bad = (dg == 4'hF);
          if (!coll) begin
            if (idx == 0) begin
              pd[0] = dg; pdp[0] = cv[0];
              nexti = 1; coll = 1; idle = 0; m_err = bad;
            end
          end else begin
            idle = 0; m_err = bad;
            if (idx == nexti) begin
              pd[idx] = dg; pdp[idx] = cv[0];
              if (idx == 5) begin
                m_digits = {pd[5], pd[4], pd[3], pd[2], pd[1], pd[0]};
                m_dp = pdp;
                m_sec = mpair(pd[1], pd[0]);
                m_min = mpair(pd[3], pd[2]);
                m_fv = 1; coll = 0;
              end else begin
                nexti++;
              end
            end else begin
              m_err = 1;
              if (idx == 0) begin
                pd[0] = dg; pdp[0] = cv[0]; nexti = 1;
              end else begin
                coll = 0;
              end
            end
          end
        end
      end else if (coll) begin
        idle++;
        if (idle == TMO) begin m_err = 1; coll = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("digits", bus.o_digits, m_digits);
      chk("dp", bus.o_dp, m_dp);
      chk("sec", bus.o_sec, m_sec);
      chk("min", bus.o_min, m_min);
      chk("frame_valid", bus.o_frame_valid, m_fv);
      chk("err", bus.o_err, m_err);
      if (bus.o_frame_valid === 1'b1) nfv++;
      if (bus.o_err === 1'b1) nerr++;
    end
  end

  task automatic drive(input logic [5:0] e, input logic [6:0] s,
                       input logic d, input int n);
    bus.i_seg_enb = e;
    bus.i_seg     = s;
    bus.i_seg_dp  = d;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] d);
    if (d < 10) return SEGS[d];
    if (d == 4'hE) return 7'h00;
    return 7'b1010101;
  endfunction

  task automatic digit(input int k, input logic [3:0] d,
                       input logic dp, input int n);
    drive(6'(~(6'd1 << k)), pat(d), dp, n);
  endtask

  task automatic scan(input logic [23:0] ds, input logic [5:0] dps,
                      input int dw);
    for (int k = 0; k < 6; k++)
      digit(k, ds[4*k +: 4], dps[k], dw);
  endtask

  task automatic counts(input string nm, input int f0, input int e0,
                        input int dfv, input int derr);
    chk({nm, "_fv_count"}, nfv - f0, dfv);
    chk({nm, "_err_count"}, nerr - e0, derr);
  endtask

  task automatic reset_values(input string nm);
    chk({nm, "_digits"}, bus.o_digits, 24'hEEEEEE);
    chk({nm, "_dp"}, bus.o_dp, 0);
    chk({nm, "_sec"}, bus.o_sec, 0);
    chk({nm, "_min"}, bus.o_min, 0);
    chk({nm, "_fv"}, bus.o_frame_valid, 0);
    chk({nm, "_err"}, bus.o_err, 0);
  endtask

  initial begin
    int f0, e0, dw, r, kk;
    logic [3:0] d;
    bus.i_seg_enb = 6'h3f;
    bus.i_seg     = 7'h00;
    bus.i_seg_dp  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    f0 = nfv; e0 = nerr;
    repeat (3) scan(24'hEE1234, 6'h00, 100);
    chk("clean_digits", bus.o_digits, 24'hEE1234);
    chk("clean_min", bus.o_min, 12);
    chk("clean_sec", bus.o_sec, 34);
    counts("clean", f0, e0, 3, 0);

    f0 = nfv; e0 = nerr;
    digit(0, 4'h4, 1'b0, 100);
    digit(1, 4'h3, 1'b0, 100);
    digit(2, 4'h2, 1'b0, 5);
    drive(6'b110111, pat(4'h2), 1'b0, 10);
    digit(2, 4'h2, 1'b0, 85);
    digit(3, 4'h1, 1'b0, 100);
    digit(4, 4'hE, 1'b0, 100);
    digit(5, 4'hE, 1'b0, 100);
    chk("glitch_digits", bus.o_digits, 24'hEE1234);
    counts("glitch", f0, e0, 1, 0);

    f0 = nfv; e0 = nerr;
    digit(0, 4'h1, 1'b0, 100);
    digit(1, 4'h2, 1'b0, 100);
    digit(3, 4'h3, 1'b0, 100);
    counts("order", f0, e0, 0, 1);
    scan(24'hEE5678, 6'b000100, 100);
    chk("order_digits", bus.o_digits, 24'hEE5678);
    chk("order_min", bus.o_min, 56);
    chk("order_sec", bus.o_sec, 78);
    chk("order_dp", bus.o_dp, 6'b000100);
    counts("order_scan", f0, e0, 1, 1);

    f0 = nfv; e0 = nerr;
    drive(6'b111100, pat(4'h1), 1'b0, 20);
    scan(24'h210959, 6'h21, 100);
    chk("multi_min", bus.o_min, 9);
    chk("multi_sec", bus.o_sec, 59);
    counts("multi", f0, e0, 1, 1);

    f0 = nfv; e0 = nerr;
    scan(24'hEE12F4, 6'h00, 100);
    chk("bad_nibble", bus.o_digits[7:4], 4'hF);
    chk("bad_sec", bus.o_sec, 127);
    chk("bad_min", bus.o_min, 12);
    counts("bad", f0, e0, 1, 1);

    f0 = nfv; e0 = nerr;
    digit(0, 4'h0, 1'b0, 100);
    digit(1, 4'h1, 1'b0, 100);
    digit(2, 4'h2, 1'b0, 100);
    drive(6'h3f, 7'h00, 1'b0, TMO + 100);
    counts("timeout", f0, e0, 0, 1);

    f0 = nfv; e0 = nerr;
    digit(0, 4'h7, 1'b0, 100);
    digit(1, 4'h8, 1'b0, 60);
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    reset_values("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    scan(24'h123456, 6'h3f, 100);
    chk("midreset_digits", bus.o_digits, 24'h123456);
    chk("midreset_min", bus.o_min, 34);
    chk("midreset_sec", bus.o_sec, 56);
    counts("midreset", f0, e0, 1, 0);

    for (int f = 0; f < 40; f++) begin
      dw = $urandom_range(20, 50);
      for (int k = 0; k < 6; k++) begin
        r = $urandom_range(0, 99);
        if (r < 8)
          drive(6'($urandom), 7'($urandom), 1'($urandom),
                $urandom_range(1, 15));
        else if (r < 12)
          drive(6'h3f, 7'($urandom), 1'b0, $urandom_range(1, 40));
        else if (r < 14)
          drive(6'($urandom), 7'($urandom), 1'($urandom), 20);
        kk = k;
        if ($urandom_range(0, 99) < 4) kk = $urandom_range(0, 5);
        r = $urandom_range(0, 40);
        d = (r < 30) ? 4'(r % 10) : (r < 40) ? 4'hE : 4'hF;
        digit(kk, d, 1'($urandom), dw);
      end
    end
    drive(6'h3f, 7'h00, 1'b0, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
